// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the io_port_bank GPIO slice.
// Register indices, reset levels and the channel-address width helper.
package io_port_pkg;

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_IN     = 3'd2;
  localparam logic [2:0] REG_MASK   = 3'd3;
  localparam logic [2:0] REG_PEND   = 3'd4;
  localparam logic [2:0] REG_TOGGLE = 3'd5;

  // Per-bit reset levels, replicated to WIDTH where used.
  localparam logic RST_OUT  = 1'b0;
  localparam logic RST_DIR  = 1'b0;
  localparam logic RST_MASK = 1'b0;
  localparam logic RST_PEND = 1'b0;
  localparam logic RST_SYNC = 1'b0;

  // Channel field width: max(1, clog2(n)).
  function automatic int ch_aw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_port_chan.sv
// io_port_chan: one GPIO channel (OUT, DIR, input synchroniser,
// optional edge/PEND/MASK when IO_PORT_EDGE_IRQ_EN is defined).
// Ports: clk, rst (async, high), clr, freeze, we (channel-decoded),
//   reg_idx, wdata, cap_en, pad_i -> out_o, dir_o, rdata_o, irq_bits_o.
module io_port_chan
  import io_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             freeze,
  input  logic             we,
  input  logic             cap_en,
  input  logic [2:0]       reg_idx,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] dir_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] irq_bits_o
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] dir_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] mask_w;
  logic [WIDTH-1:0] pend_w;
  logic wr_out;
  logic wr_dir;
  logic wr_tog;

  assign in_w   = sync_q[SYNC_STAGES-1];
  assign wr_out = we && !freeze && (reg_idx == REG_OUT);
  assign wr_dir = we && !freeze && (reg_idx == REG_DIR);
  assign wr_tog = we && !freeze && (reg_idx == REG_TOGGLE);

  // Bus write beats capture; freeze drops both.
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    if (cap_en && !freeze) out_d = in_w;
    if (wr_out) out_d = wdata;
    if (wr_tog) out_d = out_q ^ wdata;
    if (wr_dir) dir_d = wdata;
    if (clr) begin
      out_d  = {WIDTH{RST_OUT}};
      dir_d  = {WIDTH{RST_DIR}};
      sync_d = {(SYNC_STAGES*WIDTH){RST_SYNC}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= {WIDTH{RST_OUT}};
      dir_q  <= {WIDTH{RST_DIR}};
      sync_q <= {(SYNC_STAGES*WIDTH){RST_SYNC}};
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      sync_q <= sync_d;
    end
  end

`ifdef IO_PORT_EDGE_IRQ_EN
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] rise_w;
  logic wr_mask;
  logic wr_pend;

  assign wr_mask = we && !freeze && (reg_idx == REG_MASK);
  assign wr_pend = we && !freeze && (reg_idx == REG_PEND);
  assign rise_w  = in_w & ~prev_q;

  // Set is applied after the W1C so a coincident edge survives.
  always_comb begin
    prev_d = in_w;
    mask_d = mask_q;
    pend_d = pend_q;
    if (wr_mask) mask_d = wdata;
    if (wr_pend) pend_d = pend_q & ~wdata;
    pend_d = pend_d | (rise_w & mask_q);
    if (clr) begin
      prev_d = {WIDTH{RST_SYNC}};
      mask_d = {WIDTH{RST_MASK}};
      pend_d = {WIDTH{RST_PEND}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= {WIDTH{RST_SYNC}};
      mask_q <= {WIDTH{RST_MASK}};
      pend_q <= {WIDTH{RST_PEND}};
    end else begin
      prev_q <= prev_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  assign mask_w = mask_q;
  assign pend_w = pend_q;
`else
  assign mask_w = {WIDTH{RST_MASK}};
  assign pend_w = {WIDTH{RST_PEND}};
`endif

  always_comb begin
    rdata_o = '0;
    case (reg_idx)
      REG_OUT:  rdata_o = out_q;
      REG_DIR:  rdata_o = dir_q;
      REG_IN:   rdata_o = in_w;
      REG_MASK: rdata_o = mask_w;
      REG_PEND: rdata_o = pend_w;
      default:  rdata_o = '0;
    endcase
  end

  assign out_o      = out_q;
  assign dir_o      = dir_q;
  assign irq_bits_o = pend_w & mask_w;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: multi-channel GPIO bank on the 8-bit CPU bus.
// Ports: clk, rst (async, high), clr, prog_mode, addr {ch,idx},
//   wr_en, rd_en, data_in -> data_out/rd_valid; cap_en, pad_i
//   -> pad_o/pad_oe; irq. Edge IRQs need IO_PORT_EDGE_IRQ_EN.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CH_AW      = ch_aw(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      prog_mode,
  input  logic [CH_AW+2:0]          addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      rd_valid,
  input  logic [CHANNELS-1:0]       cap_en,
  input  logic [CHANNELS*WIDTH-1:0] pad_i,
  output logic [CHANNELS*WIDTH-1:0] pad_o,
  output logic [CHANNELS*WIDTH-1:0] pad_oe,
  output logic                      irq
);

  logic [CH_AW-1:0] ch_sel;
  logic [2:0]       reg_idx;
  logic [CHANNELS-1:0] ch_we;
  logic [WIDTH-1:0] ch_rdata [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] irq_bits;
  logic [WIDTH-1:0] rdata_w;
  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] data_out_d;
  logic rd_valid_q;
  logic rd_valid_d;
  logic irq_q;
  logic irq_d;

  assign ch_sel  = addr[CH_AW+2:3];
  assign reg_idx = addr[2:0];

  // Channel fields past CHANNELS match no instance: writes drop.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign ch_we[i] = wr_en && (ch_sel == CH_AW'(i));

    io_port_chan #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .freeze    (prog_mode),
      .we        (ch_we[i]),
      .cap_en    (cap_en[i]),
      .reg_idx   (reg_idx),
      .wdata     (data_in),
      .pad_i     (pad_i[i*WIDTH +: WIDTH]),
      .out_o     (pad_o[i*WIDTH +: WIDTH]),
      .dir_o     (pad_oe[i*WIDTH +: WIDTH]),
      .rdata_o   (ch_rdata[i]),
      .irq_bits_o(irq_bits[i*WIDTH +: WIDTH])
    );
  end

  // Out-of-range reads fall through to zero.
  always_comb begin
    rdata_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == CH_AW'(i)) rdata_w = ch_rdata[i];
    end
  end

  always_comb begin
    data_out_d = rd_en ? rdata_w : data_out_q;
    rd_valid_d = rd_en;
    irq_d      = |irq_bits;
    if (clr) begin
      data_out_d = '0;
      rd_valid_d = 1'b0;
      irq_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule
